spi_slave: RTL

Clock-domain SPI target that consumes the serial stream produced by `spi_master` (`scl`, `ss`, `mosi`) and returns `miso`. It oversamples the SPI pins with `clk`, shifts received bits into a 128-bit buffer, and shifts out a preloaded 128-bit transmit word. At frame end it publishes the buffer and a word count through the same 128-bit FIFO / 8-bit ctrl/status style used by `spi_master`. It sits on the far side of the SPI link and feeds the register/host logic.

---
 rtl/spi_slave.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/spi_slave.sv
// SPI target: oversamples scl/ss/mosi with clk, shifts a 128-bit rx buffer, drives miso from a preloaded tx word.
// Latency: register updates land 2 clk edges after a pin change is first captured; miso follows wbuf combinationally.
// Backpressure: none; a frame completing before the host clears done raises ovf on the next start.
module spi_slave #(
    parameter bit MODE_16B = 1'b0,
    parameter bit CPOL     = 1'b1,
    parameter bit CPHA     = 1'b1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         scl,
    input  logic         ss,
    input  logic         mosi,
    output logic         miso,
    output logic         miso_oe,
    input  logic [127:0] slv_wfifo,
    input  logic [7:0]   slv_ctrl,
    output logic [127:0] slv_rfifo,
    output logic [7:0]   slv_status
);

    localparam int         MIN_PLD  = MODE_16B ? 16 : 8;
    localparam logic [4:0] WCNT_MAX = 5'(128 / MIN_PLD);
    localparam logic [3:0] BIT_LAST = 4'(MIN_PLD - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t         state, state_nxt;
    logic           scl_s1, scl_s2, scl_s3;
    logic           ss_s1, ss_s2, ss_s3;
    logic           mosi_s1, mosi_s2;
    logic [2:0]     sync_vld;
    logic [127:0]   rbuf, wbuf;
    logic [3:0]     bit_cnt;
    logic [4:0]     wcnt, stat_wcnt;
    logic           done, ovf;
    logic           enable, clr;
    logic           start_evt, stop_evt, lead_edge, trail_edge, sample_edge;
    logic           go_active, go_idle;
    logic           unused_ctrl;

    assign enable      = slv_ctrl[7];
    assign clr         = slv_ctrl[0];
    assign unused_ctrl = ^slv_ctrl[6:1];

    // Pin synchronizers; sync_vld marks which ss stages hold real samples so a
    // low ss at reset release is not mistaken for a falling edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scl_s1   <= CPOL;
            scl_s2   <= CPOL;
            scl_s3   <= CPOL;
            ss_s1    <= 1'b1;
            ss_s2    <= 1'b1;
            ss_s3    <= 1'b1;
            mosi_s1  <= 1'b0;
            mosi_s2  <= 1'b0;
            sync_vld <= 3'b000;
        end else begin
            scl_s1   <= scl;
            scl_s2   <= scl_s1;
            scl_s3   <= scl_s2;
            ss_s1    <= ss;
            ss_s2    <= ss_s1;
            ss_s3    <= ss_s2;
            mosi_s1  <= mosi;
            mosi_s2  <= mosi_s1;
            sync_vld <= {sync_vld[1:0], 1'b1};
        end
    end

    assign start_evt   = sync_vld[2] & ss_s3 & ~ss_s2;
    assign stop_evt    = sync_vld[2] & ~ss_s3 & ss_s2;
    assign lead_edge   = (scl_s3 == CPOL) && (scl_s2 != CPOL);
    assign trail_edge  = (scl_s3 != CPOL) && (scl_s2 == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; coincident start/stop is treated as a glitch and ignored
    always_comb begin
        state_nxt = state;
        go_active = 1'b0;
        go_idle   = 1'b0;
        case (state)
            IDLE: begin
                if (start_evt && !stop_evt && enable) begin
                    state_nxt = ACTIVE;
                    go_active = 1'b1;
                end
            end
            ACTIVE: begin
                if (stop_evt && !start_evt) begin
                    state_nxt = IDLE;
                    go_idle   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift engine: load on start, rx/tx shift and word counting on each sample edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rbuf    <= '0;
            wbuf    <= '0;
            bit_cnt <= '0;
            wcnt    <= '0;
        end else if (go_active) begin
            rbuf    <= '0;
            wbuf    <= slv_wfifo;
            bit_cnt <= '0;
            wcnt    <= '0;
        end else if (state == ACTIVE && sample_edge) begin
            rbuf <= {rbuf[126:0], mosi_s2};
            wbuf <= {wbuf[126:0], 1'b0};
            if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
                if (wcnt != WCNT_MAX) begin
                    wcnt <= wcnt + 5'd1;
                end
            end else begin
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

    // Frame-end publish and sticky flags; stop beats clr for done
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slv_rfifo <= '0;
            stat_wcnt <= '0;
            done      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (go_idle) begin
                slv_rfifo <= rbuf;
                stat_wcnt <= wcnt;
            end
            if (go_idle) begin
                done <= 1'b1;
            end else if (clr) begin
                done <= 1'b0;
            end
            if (go_active && done) begin
                ovf <= 1'b1;
            end else if (clr) begin
                ovf <= 1'b0;
            end
        end
    end

    assign miso_oe    = (state == ACTIVE);
    assign miso       = (state == ACTIVE) & wbuf[127];
    assign slv_status = {miso_oe, done, ovf, stat_wcnt};

endmodule
